// File: rtl/pipeline_stage.sv
// One feature slice of the SV dot-product chain, plus result_counter, which files
// each finished chain total into a per-instance result slot.

module pipeline_stage #(
    parameter int DATA_SIZE  = 25,
    parameter int ACCUM_SIZE = 48,
    parameter int NUM_FEAT   = 2,
    parameter int IDX        = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_inner,
    input  logic                               last_inner,
    input  logic [DATA_SIZE-1:0]               sv,
    input  logic [NUM_FEAT-1:0][DATA_SIZE-1:0] curr_vector_in,
    input  logic [ACCUM_SIZE-1:0]              accum_in,
    output logic [NUM_FEAT-1:0][DATA_SIZE-1:0] curr_vector_out,
    output logic [ACCUM_SIZE-1:0]              accum_out
);
    typedef struct packed {
        logic                 start;
        logic                 last;
        logic [DATA_SIZE-1:0] sv;
    } ctl_t;

    ctl_t ctl_in, ctl_d;
    assign ctl_in = {start_inner, last_inner, sv};

    // Control and SV are skewed by IDX so they meet the test vector arriving IDX cycles late.
    generate
        if (IDX == 0) begin : g_nodly
            assign ctl_d = ctl_in;
        end else begin : g_dly
            ctl_t [IDX-1:0] dly;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dly <= '0;
                end else begin
                    dly[0] <= ctl_in;
                    for (int i = 1; i < IDX; i++) dly[i] <= dly[i-1];
                end
            end
            assign ctl_d = dly[IDX-1];
        end
    endgenerate

    // Low ACCUM_SIZE bits of a product depend only on the low ACCUM_SIZE bits of its
    // sign-extended operands, so multiplying at accumulator width gives extend-or-truncate.
    logic [ACCUM_SIZE-1:0] sv_ext, x_ext, prod, psum, psum_base;
    assign sv_ext    = ACCUM_SIZE'($signed(ctl_d.sv));
    assign x_ext     = ACCUM_SIZE'($signed(curr_vector_in[IDX]));
    assign prod      = sv_ext * x_ext;
    assign psum_base = ctl_d.start ? '0 : psum;

    always_ff @(posedge clk) begin
        if (rst) begin
            psum            <= '0;
            accum_out       <= '0;
            curr_vector_out <= '0;
        end else begin
            psum            <= psum_base + prod;
            curr_vector_out <= curr_vector_in;
            if (ctl_d.last) accum_out <= accum_in + psum_base + prod;
        end
    end
endmodule

module result_counter #(
    parameter int ACCUM_SIZE = 48,
    parameter int NUM_FEAT   = 2,
    parameter int NUM_SV     = 3,
    parameter int NUM_INST   = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               last_inner,
    input  logic [ACCUM_SIZE-1:0]              result,
    output logic [NUM_INST-1:0][ACCUM_SIZE-1:0] results
);
    // NUM_SV is carried for interface compatibility only and contributes nothing.
    localparam int IW = ((NUM_INST > 1) ? $clog2(NUM_INST) : 1) + 0 * NUM_SV;

    logic [NUM_FEAT-1:0] vld_pipe;
    logic [IW-1:0]       wr_idx;
    logic                cap;

    assign cap = vld_pipe[NUM_FEAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            wr_idx   <= '0;
            results  <= '0;
        end else if (start) begin
            vld_pipe <= '0;
            wr_idx   <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | NUM_FEAT'(last_inner);
            if (cap) begin
                results[wr_idx] <= result;
                wr_idx <= (wr_idx == IW'(NUM_INST - 1)) ? '0 : wr_idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_pipeline_stage.sv
// Two-stage chain plus result_counter, checked against directed scenarios and a
// randomized dot-product model.

module tb_pipeline_stage;
    localparam int DS = 25;
    localparam int AS = 48;
    localparam int NF = 2;
    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst, start_inner, last_inner, start;
    logic [DS-1:0] sv0, sv1;
    logic [NF-1:0][DS-1:0] vec, vec_mid, vec_out;
    logic [AS-1:0] acc0, acc1;
    logic [NI-1:0][AS-1:0] results;
    int n_chk = 0;
    int n_pass = 0;
    int sv_tab [3][2] = '{'{1, 2}, '{3, 4}, '{5, 6}};

    typedef struct {
        bit            st;
        bit            la;
        logic [DS-1:0] s0, s1, x0, x1;
    } stim_t;

    always #5 clk = ~clk;

    pipeline_stage #(.DATA_SIZE(DS), .ACCUM_SIZE(AS), .NUM_FEAT(NF), .IDX(0)) u_s0 (
        .clk(clk), .rst(rst), .start_inner(start_inner), .last_inner(last_inner),
        .sv(sv0), .curr_vector_in(vec), .accum_in('0),
        .curr_vector_out(vec_mid), .accum_out(acc0));

    pipeline_stage #(.DATA_SIZE(DS), .ACCUM_SIZE(AS), .NUM_FEAT(NF), .IDX(1)) u_s1 (
        .clk(clk), .rst(rst), .start_inner(start_inner), .last_inner(last_inner),
        .sv(sv1), .curr_vector_in(vec_mid), .accum_in(acc0),
        .curr_vector_out(vec_out), .accum_out(acc1));

    result_counter #(.ACCUM_SIZE(AS), .NUM_FEAT(NF), .NUM_SV(3), .NUM_INST(NI)) u_rc (
        .clk(clk), .rst(rst), .start(start), .last_inner(last_inner),
        .result(acc1), .results(results));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        start_inner = 1'b0;
        last_inner  = 1'b0;
        start       = 1'b0;
        sv0         = '0;
        sv1         = '0;
        vec         = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if (acc0 !== '0) $display("FAIL reset_acc0: got %h expected 0", acc0); else n_pass++;
        n_chk++; if (acc1 !== '0) $display("FAIL reset_acc1: got %h expected 0", acc1); else n_pass++;
        n_chk++; if (vec_mid !== '0) $display("FAIL reset_vec_mid: got %h expected 0", vec_mid); else n_pass++;
        n_chk++; if (vec_out !== '0) $display("FAIL reset_vec_out: got %h expected 0", vec_out); else n_pass++;
        n_chk++; if (results !== '0) $display("FAIL reset_results: got %h expected 0", results); else n_pass++;
    endtask

    // Vector (1,1) then (2,-1), each against SVs (1,2),(3,4),(5,6).
    task automatic test_example();
        for (int c = 0; c < 9; c++) begin
            idle();
            if (c < 6) begin
                start_inner = (c % 3 == 0);
                last_inner  = (c % 3 == 2);
                start       = (c == 0);
                sv0 = DS'(sv_tab[c % 3][0]);
                sv1 = DS'(sv_tab[c % 3][1]);
                vec[0] = (c < 3) ? DS'(1) : DS'(2);
                vec[1] = (c < 3) ? DS'(1) : DS'(-1);
            end
            tick();
            if (c + 1 == 3) begin
                n_chk++; if (acc0 !== 48'd9) $display("FAIL ex_acc0_c3: got %0d expected 9", acc0); else n_pass++;
            end
            if (c + 1 == 4) begin
                n_chk++; if (acc1 !== 48'd21) $display("FAIL ex_acc1_c4: got %0d expected 21", acc1); else n_pass++;
            end
            if (c + 1 == 5) begin
                n_chk++; if (results[0] !== 48'd21) $display("FAIL ex_res0_c5: got %0d expected 21", results[0]); else n_pass++;
            end
            if (c + 1 == 6) begin
                n_chk++; if (acc0 !== 48'd18) $display("FAIL ex_acc0_c6: got %0d expected 18", acc0); else n_pass++;
                n_chk++; if (acc1 !== 48'd21) $display("FAIL ex_acc1_hold: got %0d expected 21", acc1); else n_pass++;
            end
            if (c + 1 == 7) begin
                n_chk++; if (acc1 !== 48'd6) $display("FAIL ex_acc1_c7: got %0d expected 6", acc1); else n_pass++;
            end
            if (c + 1 == 8) begin
                n_chk++; if (results[1] !== 48'd6) $display("FAIL ex_res1_c8: got %0d expected 6", results[1]); else n_pass++;
                n_chk++; if (results[0] !== 48'd21) $display("FAIL ex_res0_c8: got %0d expected 21", results[0]); else n_pass++;
            end
        end
    endtask

    task automatic test_negative();
        idle();
        start = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            idle();
            if (c == 0) begin
                start_inner = 1'b1;
                last_inner  = 1'b1;
                sv0 = DS'(-1);
                vec[0] = DS'(1);
            end
            tick();
            if (c + 1 == 2) begin
                n_chk++; if (acc1 !== 48'hFFFF_FFFF_FFFF) $display("FAIL neg_acc1: got %h expected ffffffffffff", acc1); else n_pass++;
            end
            if (c + 1 == 3) begin
                n_chk++; if (results[0] !== 48'hFFFF_FFFF_FFFF) $display("FAIL neg_res0: got %h expected ffffffffffff", results[0]); else n_pass++;
            end
        end
    endtask

    // Three captures wrap to slot 0; a start right after a last drops that capture and rewinds.
    task automatic test_wrap_restart();
        idle();
        start = 1'b1;
        tick();
        for (int c = 0; c < 11; c++) begin
            idle();
            if (c < 3) begin
                start_inner = 1'b1; last_inner = 1'b1;
                sv0 = DS'(10 * (c + 1)); sv1 = DS'(1);
                vec[0] = DS'(1); vec[1] = DS'(1);
            end else if (c == 5 || c == 8) begin
                start_inner = 1'b1; last_inner = 1'b1;
                sv0 = (c == 5) ? DS'(7) : DS'(5);
                vec[0] = DS'(1);
            end
            start = (c == 6);
            tick();
            if (c + 1 == 3) begin
                n_chk++; if (results[0] !== 48'd11) $display("FAIL wrap_res0_first: got %0d expected 11", results[0]); else n_pass++;
            end
            if (c + 1 == 4) begin
                n_chk++; if (results[1] !== 48'd21) $display("FAIL wrap_res1: got %0d expected 21", results[1]); else n_pass++;
            end
            if (c + 1 == 5) begin
                n_chk++; if (results[0] !== 48'd31) $display("FAIL wrap_res0_wrapped: got %0d expected 31", results[0]); else n_pass++;
            end
            if (c + 1 == 7) begin
                n_chk++; if (acc1 !== 48'd7) $display("FAIL wrap_acc1_abort: got %0d expected 7", acc1); else n_pass++;
            end
            if (c + 1 == 9) begin
                n_chk++; if (results !== {48'd21, 48'd31}) $display("FAIL wrap_no_capture: got %h expected %h", results, {48'd21, 48'd31}); else n_pass++;
            end
            if (c + 1 == 11) begin
                n_chk++; if (results !== {48'd21, 48'd5}) $display("FAIL restart_res0: got %h expected %h", results, {48'd21, 48'd5}); else n_pass++;
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c < 3) begin
                start_inner = (c == 0);
                last_inner  = (c == 2);
                sv0 = DS'(sv_tab[c][0]);
                sv1 = DS'(sv_tab[c][1]);
                vec[0] = DS'(1); vec[1] = DS'(1);
            end
            rst = (c == 3);
            tick();
            if (c + 1 == 3) begin
                n_chk++; if (acc0 !== 48'd9) $display("FAIL mrst_acc0_live: got %0d expected 9", acc0); else n_pass++;
            end
            if (c + 1 == 4) begin
                n_chk++; if ({acc0, acc1, vec_mid, vec_out} !== '0) $display("FAIL mrst_stage_zero: got %h/%h/%h/%h expected 0", acc0, acc1, vec_mid, vec_out); else n_pass++;
            end
            if (c + 1 >= 4) begin
                n_chk++; if (results !== '0) $display("FAIL mrst_results_c%0d: got %h expected 0", c + 1, results); else n_pass++;
            end
            if (c + 1 >= 5) begin
                n_chk++; if (acc1 !== '0) $display("FAIL mrst_acc1_c%0d: got %h expected 0", c + 1, acc1); else n_pass++;
            end
        end
        rst = 1'b0;
    endtask

    // Score of an instance = sum over its SVs of sv.x, reduced mod 2^48; slots fill round-robin.
    task automatic test_random();
        stim_t s;
        stim_t stim[$];
        int due_a[$], due_r[$];
        logic [AS-1:0] exp_a[$];
        logic [NI-1:0][AS-1:0] exp_r[$];
        logic [NI-1:0][AS-1:0] m_res;
        logic [DS-1:0] x0, x1;
        longint sum;
        int nsv, m_idx, last_c;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_res = '0;
        m_idx = 0;
        for (int n = 0; n < 30; n++) begin
            nsv = $urandom_range(1, 4);
            x0 = DS'($urandom);
            x1 = DS'($urandom);
            sum = 0;
            for (int k = 0; k < nsv; k++) begin
                s.st = (k == 0); s.la = (k == nsv - 1);
                s.s0 = DS'($urandom); s.s1 = DS'($urandom);
                s.x0 = x0; s.x1 = x1;
                sum += longint'($signed(s.s0)) * longint'($signed(x0))
                     + longint'($signed(s.s1)) * longint'($signed(x1));
                stim.push_back(s);
            end
            last_c = stim.size() - 1;
            due_a.push_back(last_c + 2);
            exp_a.push_back(AS'(sum));
            m_res[m_idx] = AS'(sum);
            m_idx = (m_idx + 1) % NI;
            due_r.push_back(last_c + 3);
            exp_r.push_back(m_res);
            repeat ($urandom_range(0, 2)) begin
                s.st = 1'b0; s.la = 1'b0;
                s.s0 = DS'($urandom); s.s1 = DS'($urandom);
                s.x0 = DS'($urandom); s.x1 = DS'($urandom);
                stim.push_back(s);
            end
        end
        for (int c = 0; c < stim.size() + 4; c++) begin
            idle();
            if (c < stim.size()) begin
                start_inner = stim[c].st; last_inner = stim[c].la;
                sv0 = stim[c].s0; sv1 = stim[c].s1;
                vec[0] = stim[c].x0; vec[1] = stim[c].x1;
            end
            tick();
            if (c >= 1 && c - 1 < stim.size()) begin
                n_chk++;
                if (vec_out !== {stim[c-1].x1, stim[c-1].x0})
                    $display("FAIL rand_vec_out cyc %0d: got %h expected %h", c + 1, vec_out, {stim[c-1].x1, stim[c-1].x0});
                else n_pass++;
            end
            if (due_a.size() > 0 && due_a[0] == c + 1) begin
                n_chk++;
                if (acc1 !== exp_a[0]) $display("FAIL rand_accum cyc %0d: got %h expected %h", c + 1, acc1, exp_a[0]);
                else n_pass++;
                void'(due_a.pop_front());
                void'(exp_a.pop_front());
            end
            if (due_r.size() > 0 && due_r[0] == c + 1) begin
                n_chk++;
                if (results !== exp_r[0]) $display("FAIL rand_results cyc %0d: got %h expected %h", c + 1, results, exp_r[0]);
                else n_pass++;
                void'(due_r.pop_front());
                void'(exp_r.pop_front());
            end
        end
        n_chk++;
        if (due_a.size() + due_r.size() != 0) $display("FAIL rand_pending: got %0d unchecked expected 0", due_a.size() + due_r.size());
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_example();
        test_negative();
        test_wrap_restart();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipeline_stage.md
PIPELINE_STAGE -- requirements
Module: pipeline_stage (companion module result_counter specified in the same document)

Interface
REQ-001 Parameters of pipeline_stage, in positional order:
- DATA_SIZE, default 25, operand width.
- ACCUM_SIZE, default 48, accumulator width.
- NUM_FEAT, default 2, number of features (stages).
- IDX, default 0, index of this stage's feature.

REQ-002 Parameters of result_counter, in positional order:
- ACCUM_SIZE, default 48.
- NUM_FEAT, default 2.
- NUM_SV, default 3, accepted but has no effect on logic.
- NUM_INST, default 2, number of result slots.

REQ-003 pipeline_stage ports:
- clk, in, 1, single clock, all logic on rising edge.
- rst, in, 1, reset is synchronous and active-high.
- start_inner, in, 1, first support vector (SV) of an instance.
- last_inner, in, 1, last SV of an instance.
- sv, in, DATA_SIZE, feature IDX of the current SV.
- curr_vector_in, in, NUM_FEAT x DATA_SIZE, test vector arriving IDX cycles late.
- accum_in, in, ACCUM_SIZE, total from stage IDX-1 (0 for stage 0).
- curr_vector_out, out, NUM_FEAT x DATA_SIZE, curr_vector_in registered.
- accum_out, out, ACCUM_SIZE, running total through this stage.

REQ-004 result_counter ports:
- clk, in, 1, single clock.
- rst, in, 1, reset is synchronous and active-high.
- start, in, 1, begin a new run.
- last_inner, in, 1, same pulse fed to stage 0.
- result, in, ACCUM_SIZE, accum_out of stage NUM_FEAT-1.
- results, out, NUM_INST x ACCUM_SIZE, captured per-instance scores.

Function
REQ-005 pipeline_stage: sv, start_inner and last_inner pass through an internal delay line of exactly IDX registers before use. IDX=0 means no delay and combinational use. These delayed values are sv_d, start_d and last_d.
REQ-006 The product prod = sv_d * curr_vector_in[IDX]. Both operands are signed two's complement. The product is sign-extended or truncated to ACCUM_SIZE.
REQ-007 The partial-sum register psum updates every cycle:
- start_d=1: psum <= prod.
- otherwise: psum <= psum + prod.
REQ-008 Cycle where last_d=1: accum_out <= accum_in + psum + prod, computed as if start_d=1 made psum 0. In all other cycles accum_out holds its value.
REQ-009 curr_vector_out <= curr_vector_in every cycle, one cycle of latency.
REQ-010 All arithmetic wraps modulo 2^ACCUM_SIZE, with no saturation or overflow flag.
REQ-011 start_d and last_d may be asserted in the same cycle (an instance with one SV). accum_out then becomes accum_in + prod.
REQ-012 Chain latency: stage NUM_FEAT-1 accum_out equals sum over SVs and features of sv*x. It is valid NUM_FEAT cycles after the cycle in which stage 0 sees last_inner, and holds until the next instance completes.
REQ-013 result_counter:
- Delays last_inner through a shift register of NUM_FEAT stages, producing cap.
- When cap=1: results[wr_idx] <= result, and wr_idx increments, wrapping from NUM_INST-1 to 0.
- start=1 clears wr_idx to 0 and clears the delay line; start takes priority over cap in the same cycle.
- results entries not being written hold their value.
REQ-014 In a given cycle, a captured result is visible on results one cycle after cap.

Reset
REQ-015 rst=1 at a rising edge clears all of the following to 0: the delay lines, psum, accum_out, curr_vector_out, wr_idx and every results entry.
REQ-016 Reset mid-operation abandons the run. Outputs read 0 on the cycle after the reset edge.

Verification
Common setup: DATA_SIZE=25, ACCUM_SIZE=48, NUM_FEAT=2, NUM_SV=3, NUM_INST=2. SVs are (1,2), (3,4), (5,6). Cycle 0 is the start cycle.
REQ-017 Reset: apply rst=1 for one edge -> all outputs read 0.
REQ-018 Test vector (1,1) held for cycles 0-2, start_inner at cycle 0, last_inner at cycle 2 -> stage 1 accum_out=21 from cycle 4, and results[0]=21 from cycle 5.
REQ-019 Test vector (2,-1) on cycles 3-5, after (1,1) -> results[1]=6 from cycle 8, and results[0] stays 21.
REQ-020 Negative check: SV (-1,0) with test vector (1,0), one SV per instance -> result is 48'hFFFFFFFFFFFF.
REQ-021 Wrap and restart: a third capture pulse writes results[0]; start asserted mid-run resets wr_idx so the next capture goes to results[0].
REQ-022 Reset asserted at cycle 3 of a run -> no later capture occurs, and all outputs are 0.
